// File: rtl/boa_extmem_rom_if.sv
// Bus bundle for the external-ROM boa_mem_bus port.
// The initiator drives the request side and the ROM responder drives ready/rdata.
interface boa_extmem_rom_if #(
    parameter int ALEN = 19
) ();
    logic            re;
    logic [3:0]      we;
    logic [ALEN-1:0] addr;
    logic [31:0]     wdata;
    logic            ready;
    logic [31:0]     rdata;

    modport master (
        output re, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  re, we, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/boa_extmem_rom.sv
// External-ROM responder: assembles 32-bit words from a byte-wide async ROM with wait states,
// and serves repeated reads of the last fetched word from a one-entry buffer.
module boa_extmem_rom #(
    parameter int ALEN        = 19,
    parameter int WAIT_STATES = 2,
    parameter bit BUF_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    boa_extmem_rom_if.slave       bus,
    output logic [ALEN-1:0]       rom_addr,
    output logic                  rom_oe,
    input  logic [7:0]            rom_rdata
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t          state;
    logic            buf_valid;
    logic [ALEN-3:0] buf_tag;
    logic [31:0]     buf_data;
    logic [ALEN-3:0] tag;
    logic [1:0]      byte_idx;
    logic [3:0]      wait_cnt;
    logic            hit;

    // Writes and the byte offset never influence the response; kept only so nothing dangles.
    logic unused_bits;
    assign unused_bits = ^{bus.we, bus.wdata, bus.addr[1:0]};

    assign hit = buf_valid && (bus.addr[ALEN-1:2] == buf_tag);

    // In IDLE, only a missing read stalls; writes and idle cycles complete immediately.
    always_comb begin
        bus.ready = 1'b0;
        bus.rdata = 32'h0;
        if (state == IDLE) begin
            if (bus.re) begin
                bus.ready = hit;
                if (hit) begin
                    bus.rdata = buf_data;
                end
            end else begin
                bus.ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= 32'h0;
            tag       <= '0;
            byte_idx  <= 2'd0;
            wait_cnt  <= 4'd0;
            rom_addr  <= '0;
            rom_oe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.re) begin
                        if (hit) begin
                            if (!BUF_EN) begin
                                buf_valid <= 1'b0;
                            end
                        end else begin
                            tag      <= bus.addr[ALEN-1:2];
                            byte_idx <= 2'd0;
                            wait_cnt <= 4'(WAIT_STATES);
                            rom_addr <= {bus.addr[ALEN-1:2], 2'b00};
                            rom_oe   <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // The ROM byte is sampled on the last cycle of its address window.
                    if (wait_cnt == 4'd0) begin
                        buf_data[8*byte_idx +: 8] <= rom_rdata;
                        if (byte_idx == 2'd3) begin
                            buf_tag   <= tag;
                            buf_valid <= 1'b1;
                            rom_oe    <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            rom_addr <= rom_addr + 1'b1;
                            wait_cnt <= 4'(WAIT_STATES);
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boa_extmem_rom.sv
// Directed bench for boa_extmem_rom: two instances (buffered WAIT_STATES=2, unbuffered WAIT_STATES=0)
// share one clock; read data is checked through a scoreboard queue filled when each read is issued.
module tb_boa_extmem_rom;

    localparam int ALEN = 19;
    localparam int WS_A = 2;
    localparam int WS_B = 0;
    // Ready-low cycles of a miss, counting the cycle in which the miss is first seen.
    localparam int MISS_A = 4 * (WS_A + 1) + 1;
    localparam int MISS_B = 4 * (WS_B + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ALEN-1:0] rom_addr_a, rom_addr_b;
    logic rom_oe_a, rom_oe_b;
    logic [7:0] rom_rdata_a, rom_rdata_b;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    bit sel = 1'b0;

    boa_extmem_rom_if #(.ALEN(ALEN)) bus_a ();
    boa_extmem_rom_if #(.ALEN(ALEN)) bus_b ();

    boa_extmem_rom #(.ALEN(ALEN), .WAIT_STATES(WS_A), .BUF_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .rom_addr(rom_addr_a), .rom_oe(rom_oe_a), .rom_rdata(rom_rdata_a)
    );

    boa_extmem_rom #(.ALEN(ALEN), .WAIT_STATES(WS_B), .BUF_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .rom_addr(rom_addr_b), .rom_oe(rom_oe_b), .rom_rdata(rom_rdata_b)
    );

    assign rom_rdata_a = rom_addr_a[7:0] ^ 8'h5A;
    assign rom_rdata_b = rom_addr_b[7:0] ^ 8'h5A;

    always #5 clk = ~clk;

    function automatic logic [7:0] romByte(input logic [ALEN-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] romWord(input logic [ALEN-1:0] a);
        logic [ALEN-1:0] base;
        base = {a[ALEN-1:2], 2'b00};
        return {romByte(base + 19'd3), romByte(base + 19'd2), romByte(base + 19'd1), romByte(base)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input logic re, input logic [3:0] we,
                                 input logic [ALEN-1:0] addr, input logic [31:0] wdata);
        if (s) begin
            bus_b.re = re; bus_b.we = we; bus_b.addr = addr; bus_b.wdata = wdata;
        end else begin
            bus_a.re = re; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata;
        end
    endtask

    function automatic logic selReady();
        return sel ? bus_b.ready : bus_a.ready;
    endfunction

    function automatic logic [31:0] selRdata();
        return sel ? bus_b.rdata : bus_a.rdata;
    endfunction

    // Issue a read at posedge+1, count ready-low samples at negedges, then compare data and latency.
    task automatic doRead(input bit s, input logic [ALEN-1:0] addr, input int exp_wait,
                          input bit trace, input string name);
        int waits;
        logic [ALEN-1:0] base;
        base = {addr[ALEN-1:2], 2'b00};
        sel = s;
        exp_q.push_back(romWord(addr));
        applyStimulus(s, 1'b1, 4'h0, addr, 32'h0);
        waits = 0;
        @(negedge clk);
        while (!selReady() && waits < 200) begin
            waits++;
            @(negedge clk);
            if (trace && !selReady()) begin
                checkOutput({name, "_rom_addr"}, 32'(rom_addr_a), 32'(base + 19'((waits - 1) / (WS_A + 1))));
                checkOutput({name, "_rom_oe"}, 32'(rom_oe_a), 32'd1);
            end
        end
        if (selReady()) begin
            checkOutput({name, "_rdata"}, selRdata(), exp_q.pop_front());
            checkOutput({name, "_latency"}, 32'(waits), 32'(exp_wait));
        end else begin
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        applyStimulus(s, 1'b0, 4'h0, addr, 32'h0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 4'h0, '0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, '0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset_ready", 32'(bus_a.ready), 32'd1);
        checkOutput("reset_rdata", bus_a.rdata, 32'h0);
        checkOutput("reset_rom_oe", 32'(rom_oe_a), 32'd0);
        checkOutput("reset_rom_addr", 32'(rom_addr_a), 32'd0);
        @(posedge clk);
        #1;

        // 1) cold miss with rom_addr trace
        doRead(1'b0, 19'h100, MISS_A, 1'b1, "miss_100");

        // 2) hits on the same word, ROM stays idle
        doRead(1'b0, 19'h100, 0, 1'b0, "hit_100");
        checkOutput("hit_rom_oe", 32'(rom_oe_a), 32'd0);
        doRead(1'b0, 19'h102, 0, 1'b0, "hit_102");
        checkOutput("hit2_rom_oe", 32'(rom_oe_a), 32'd0);

        // 3) new word misses, old word then misses again
        doRead(1'b0, 19'h104, MISS_A, 1'b0, "miss_104");
        doRead(1'b0, 19'h100, MISS_A, 1'b0, "remiss_100");

        // 4) write completes immediately and leaves the buffer intact
        applyStimulus(1'b0, 1'b0, 4'hF, 19'h100, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("write_ready", 32'(bus_a.ready), 32'd1);
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, 4'h0, 19'h100, 32'h0);
        doRead(1'b0, 19'h100, 0, 1'b0, "after_write_100");

        // 5) reset in the 5th fetch cycle discards the fetch and the buffer
        sel = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'h0, 19'h200, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("abort_ready_low", 32'(bus_a.ready), 32'd0);
        end
        checkOutput("abort_rom_addr", 32'(rom_addr_a), 32'h201);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 19'h200, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_rom_oe", 32'(rom_oe_a), 32'd0);
        checkOutput("abort_idle_ready", 32'(bus_a.ready), 32'd1);
        @(posedge clk);
        #1;
        doRead(1'b0, 19'h100, MISS_A, 1'b0, "post_rst_100");
        doRead(1'b0, 19'h200, MISS_A, 1'b0, "post_rst_200");

        // 6) unbuffered, zero-wait instance: every read misses
        doRead(1'b1, 19'h100, MISS_B, 1'b0, "nobuf_100");
        doRead(1'b1, 19'h100, MISS_B, 1'b0, "nobuf_again_100");
        checkOutput("nobuf_rom_oe", 32'(rom_oe_b), 32'd0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
